// File: rtl/clock_pkg.sv
// Shared encodings for the digital clock front end: mode codes, button
// indices and the alarm state machine states.
package clock_pkg;

    localparam logic [1:0] ST_CLOCK     = 2'b00;
    localparam logic [1:0] ST_STOPWATCH = 2'b01;
    localparam logic [1:0] ST_ALARM     = 2'b10;
    localparam logic [1:0] ST_TIMER     = 2'b11;

    localparam int BTN_MIN   = 3;
    localparam int BTN_SEC   = 2;
    localparam int BTN_RST   = 1;
    localparam int BTN_START = 0;

    typedef enum logic [1:0] {
        ALM_DISARMED = 2'b00,
        ALM_ARMED    = 2'b01,
        ALM_RINGING  = 2'b10,
        ALM_SNOOZE   = 2'b11
    } alm_state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Board-side signal bundle of the alarm/mode controller: raw buttons,
// time values in, mode/pulses/alarm status out.
interface alarm_ctrl_if;
    logic [3:0] btn_raw;
    logic       mode_btn;
    logic       tick_1hz;
    logic [5:0] cur_mm;
    logic [5:0] cur_ss;
    logic [5:0] alm_mm;
    logic [5:0] alm_ss;
    logic [1:0] st;
    logic [3:0] btn_pulse;
    logic       armed;
    logic       buzzer;

    modport master (
        output btn_raw, mode_btn, tick_1hz, cur_mm, cur_ss, alm_mm, alm_ss,
        input  st, btn_pulse, armed, buzzer
    );

    modport slave (
        input  btn_raw, mode_btn, tick_1hz, cur_mm, cur_ss, alm_mm, alm_ss,
        output st, btn_pulse, armed, buzzer
    );
endinterface

// File: rtl/btn_sync_edge.sv
// Per-bit 2-flop synchroniser plus history flop; produces a registered
// one-cycle rise pulse for each asynchronous input.
module btn_sync_edge #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] rise
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic sync1_reg;
            logic sync2_reg;
            logic hist_reg;
            logic rise_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    hist_reg  <= 1'b0;
                    rise_reg  <= 1'b0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    hist_reg  <= sync2_reg;
                    rise_reg  <= sync2_reg & ~hist_reg;
                end
            end

            assign rise[gi] = rise_reg;
        end
    endgenerate

endmodule

// File: rtl/alarm_ctrl.sv
// Mode cycling, gated button pulse forwarding and the alarm
// arm/ring/snooze state machine for the digital clock.
module alarm_ctrl
    import clock_pkg::*;
#(
    parameter int RING_SECS   = 30,
    parameter int SNOOZE_SECS = 300
) (
    input  logic         wt_clk,
    input  logic         rst_n,
    alarm_ctrl_if.slave  bus
);

    localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);

    logic [4:0] rise;
    logic [3:0] btn_rise;
    logic       mode_rise;

    btn_sync_edge #(.WIDTH(5)) u_sync (
        .clk   (wt_clk),
        .rst_n (rst_n),
        .raw   ({bus.mode_btn, bus.btn_raw}),
        .rise  (rise)
    );

    assign btn_rise  = rise[3:0];
    assign mode_rise = rise[4];

    alm_state_t state_reg, state_next;
    logic [8:0] ring_cnt_reg, ring_cnt_next;
    logic [8:0] snz_cnt_reg, snz_cnt_next;
    logic [1:0] st_reg, st_next;
    logic [3:0] pulse_reg, pulse_next;
    logic       armed_reg, buzzer_reg;
    logic       alarm_busy;
    logic       time_match;

    assign time_match = (bus.cur_mm == bus.alm_mm) && (bus.cur_ss == bus.alm_ss);

    always_comb begin
        state_next    = state_reg;
        ring_cnt_next = ring_cnt_reg;
        snz_cnt_next  = snz_cnt_reg;
        st_next       = st_reg;
        pulse_next    = 4'd0;
        alarm_busy    = (state_reg == ALM_RINGING) || (state_reg == ALM_SNOOZE);

        // While the alarm is active the mode button is a dismiss, not a mode step
        if (mode_rise && !alarm_busy)
            st_next = st_reg + 2'd1;
        if (is_onehot4(btn_rise) && !mode_rise && !alarm_busy)
            pulse_next = btn_rise;

        case (state_reg)
            ALM_DISARMED: begin
                if (btn_rise[BTN_START] && st_reg == ST_CLOCK)
                    state_next = ALM_ARMED;
            end
            ALM_ARMED: begin
                if (btn_rise[BTN_START] && st_reg == ST_CLOCK)
                    state_next = ALM_DISARMED;
                else if (bus.tick_1hz && time_match)
                    state_next = ALM_RINGING;
            end
            ALM_RINGING: begin
                if (btn_rise[BTN_RST] || mode_rise)
                    state_next = ALM_ARMED;
                else if (btn_rise[BTN_START])
                    state_next = ALM_SNOOZE;
                else if (bus.tick_1hz) begin
                    if (ring_cnt_reg == RING_LAST)
                        state_next = ALM_ARMED;
                    else
                        ring_cnt_next = ring_cnt_reg + 9'd1;
                end
            end
            ALM_SNOOZE: begin
                if (btn_rise[BTN_RST] || mode_rise)
                    state_next = ALM_ARMED;
                else if (bus.tick_1hz) begin
                    if (snz_cnt_reg == SNOOZE_LAST)
                        state_next = ALM_RINGING;
                    else
                        snz_cnt_next = snz_cnt_reg + 9'd1;
                end
            end
            default: state_next = ALM_DISARMED;
        endcase

        if (state_next != state_reg) begin
            ring_cnt_next = 9'd0;
            snz_cnt_next  = 9'd0;
        end
    end

    // Status outputs decode the next state so they line up with state_reg
    always_ff @(posedge wt_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ALM_DISARMED;
            ring_cnt_reg <= 9'd0;
            snz_cnt_reg  <= 9'd0;
            st_reg       <= ST_CLOCK;
            pulse_reg    <= 4'd0;
            armed_reg    <= 1'b0;
            buzzer_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ring_cnt_reg <= ring_cnt_next;
            snz_cnt_reg  <= snz_cnt_next;
            st_reg       <= st_next;
            pulse_reg    <= pulse_next;
            armed_reg    <= (state_next != ALM_DISARMED);
            buzzer_reg   <= (state_next == ALM_RINGING);
        end
    end

    assign bus.st        = st_reg;
    assign bus.btn_pulse = pulse_reg;
    assign bus.armed     = armed_reg;
    assign bus.buzzer    = buzzer_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scenario bench for alarm_ctrl: expected button pulses (cycle, value) are
// queued when stimulus is driven and matched against pulses the DUT emits.
module tb_alarm_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    logic [35:0] exp_q[$];
    logic [35:0] obs_q[$];

    alarm_ctrl_if bus ();

    alarm_ctrl #(.RING_SECS(30), .SNOOZE_SECS(300)) dut (
        .wt_clk (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.btn_pulse !== 4'b0000)
            obs_q.push_back({cyc[31:0], bus.btn_pulse});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        bus.tick_1hz = 1'b1;
        step(1);
        bus.tick_1hz = 1'b0;
        step(1);
    endtask

    task automatic check_bit(input string name, input logic got, input logic need);
        tests++;
        $display("[TB] %s got=%b need=%b", name, got, need);
        if (got !== need) begin
            failed++;
            $display("FAIL %s: got %b, need %b", name, got, need);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.btn_raw = 4'd0; bus.mode_btn = 1'b0; bus.tick_1hz = 1'b0;
        bus.cur_mm = 6'd0; bus.cur_ss = 6'd0; bus.alm_mm = 6'd0; bus.alm_ss = 6'd0;
        step(3);
        rst_n = 1'b1;
        step(2);
        tests++;
        $display("[TB] reset st=%b pulse=%b armed=%b buzzer=%b", bus.st, bus.btn_pulse, bus.armed, bus.buzzer);
        if ({bus.st, bus.btn_pulse, bus.armed, bus.buzzer} !== 8'd0) begin
            failed++;
            $display("FAIL reset_state: got st=%b pulse=%b armed=%b buzzer=%b, need all zero",
                     bus.st, bus.btn_pulse, bus.armed, bus.buzzer);
        end
    endtask

    task automatic test_single_pulse();
        logic [35:0] e, g;
        bus.btn_raw = 4'b0100;
        exp_q.push_back({32'(cyc + 4), 4'b0100});
        step(20);
        bus.btn_raw = 4'b0000;
        step(6);
        tests++;
        if (bus.st !== 2'b00) begin
            failed++;
            $display("FAIL t1_st: got %b, need 00", bus.st);
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            failed++;
            $display("FAIL t1_count: got %0d pulses, need %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            g = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
            tests++;
            $display("[TB] t1 pulse cyc=%0d val=%b", g[35:4], g[3:0]);
            if (g !== e) begin
                failed++;
                $display("FAIL t1_pulse: got cyc=%0d val=%b, need cyc=%0d val=%b", g[35:4], g[3:0], e[35:4], e[3:0]);
            end
        end
    endtask

    task automatic test_gating_and_mode();
        logic [1:0] need_st;
        logic [35:0] e, g;
        bus.btn_raw = 4'b1100;
        step(10);
        bus.btn_raw = 4'b0000;
        step(6);
        for (int i = 1; i <= 4; i++) begin
            need_st = 2'(i);
            bus.mode_btn = 1'b1;
            if (i == 4) bus.btn_raw = 4'b0100;
            step(6);
            bus.mode_btn = 1'b0;
            bus.btn_raw = 4'b0000;
            step(6);
            tests++;
            $display("[TB] mode press %0d st=%b", i, bus.st);
            if (bus.st !== need_st) begin
                failed++;
                $display("FAIL t2_st%0d: got %b, need %b", i, bus.st, need_st);
            end
        end
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            failed++;
            $display("FAIL t2_count: got %0d pulses, need %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            g = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
            tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL t2_pulse: got cyc=%0d val=%b, need cyc=%0d val=%b", g[35:4], g[3:0], e[35:4], e[3:0]);
            end
        end
    endtask

    task automatic test_arm_and_ring();
        logic [35:0] e, g;
        bus.alm_mm = 6'd5; bus.alm_ss = 6'd10;
        bus.cur_mm = 6'd5; bus.cur_ss = 6'd9;
        bus.btn_raw = 4'b0001;
        exp_q.push_back({32'(cyc + 4), 4'b0001});
        step(6);
        bus.btn_raw = 4'b0000;
        step(4);
        check_bit("t3_armed", bus.armed, 1'b1);
        tick_once();
        check_bit("t3_no_match", bus.buzzer, 1'b0);
        bus.cur_ss = 6'd10;
        bus.tick_1hz = 1'b1;
        step(1);
        bus.tick_1hz = 1'b0;
        check_bit("t3_ring", bus.buzzer, 1'b1);
        step(3);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            failed++;
            $display("FAIL t3_count: got %0d pulses, need %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            g = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
            tests++;
            $display("[TB] t3 pulse cyc=%0d val=%b", g[35:4], g[3:0]);
            if (g !== e) begin
                failed++;
                $display("FAIL t3_pulse: got cyc=%0d val=%b, need cyc=%0d val=%b", g[35:4], g[3:0], e[35:4], e[3:0]);
            end
        end
    endtask

    task automatic test_snooze();
        logic [35:0] e, g;
        bus.btn_raw = 4'b0001;
        step(6);
        bus.btn_raw = 4'b0000;
        check_bit("t4_snooze_buzzer", bus.buzzer, 1'b0);
        check_bit("t4_snooze_armed", bus.armed, 1'b1);
        step(4);
        for (int i = 0; i < 299; i++) tick_once();
        check_bit("t4_299_ticks", bus.buzzer, 1'b0);
        tick_once();
        check_bit("t4_re_ring", bus.buzzer, 1'b1);
        bus.btn_raw = 4'b0010;
        step(6);
        bus.btn_raw = 4'b0000;
        step(4);
        check_bit("t4_dismiss_buzzer", bus.buzzer, 1'b0);
        check_bit("t4_dismiss_armed", bus.armed, 1'b1);
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            failed++;
            $display("FAIL t4_count: got %0d pulses, need %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            g = (obs_q.size() != 0) ? obs_q.pop_front() : '1;
            tests++;
            if (g !== e) begin
                failed++;
                $display("FAIL t4_pulse: got cyc=%0d val=%b, need cyc=%0d val=%b", g[35:4], g[3:0], e[35:4], e[3:0]);
            end
        end
    endtask

    task automatic test_ring_timeout();
        tick_once();
        check_bit("t5_ring_start", bus.buzzer, 1'b1);
        for (int i = 0; i < 29; i++) tick_once();
        check_bit("t5_29_ticks", bus.buzzer, 1'b1);
        tick_once();
        check_bit("t5_timeout", bus.buzzer, 1'b0);
        check_bit("t5_timeout_armed", bus.armed, 1'b1);
        tick_once();
        check_bit("t5_rematch", bus.buzzer, 1'b1);
        // btn1 edge reaches the FSM on the 4th edge after the raw rise
        bus.btn_raw = 4'b0010;
        step(3);
        bus.tick_1hz = 1'b1;
        step(1);
        bus.tick_1hz = 1'b0;
        check_bit("t5_dismiss_wins", bus.buzzer, 1'b0);
        step(3);
        bus.btn_raw = 4'b0000;
        step(4);
        tests++;
        if (obs_q.size() != 0) begin
            failed++;
            $display("FAIL t5_count: got %0d pulses, need 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_async_reset();
        bus.mode_btn = 1'b1;
        step(6);
        bus.mode_btn = 1'b0;
        step(4);
        tests++;
        if (bus.st !== 2'b01) begin
            failed++;
            $display("FAIL t6_st_before: got %b, need 01", bus.st);
        end
        tick_once();
        check_bit("t6_ringing", bus.buzzer, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("t6_buzzer_async", bus.buzzer, 1'b0);
        check_bit("t6_armed_async", bus.armed, 1'b0);
        tests++;
        if (bus.st !== 2'b00) begin
            failed++;
            $display("FAIL t6_st_async: got %b, need 00", bus.st);
        end
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_gating_and_mode();
        test_arm_and_ring();
        test_snooze();
        test_ring_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
